// File: rtl/snes_pkg.sv
// Shared types and constants for the multi-source SNES controller encoder.
package snes_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    AUTO  = 2'b01,
    MERGE = 2'b10,
    MUTE  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } frame_state_e;

  localparam int SNES_FRAME_BITS = 16;

  // Button positions within a source word, in console shift order
  localparam int B      = 0;
  localparam int Y      = 1;
  localparam int SELECT = 2;
  localparam int START  = 3;
  localparam int UP     = 4;
  localparam int DOWN   = 5;
  localparam int LEFT   = 6;
  localparam int RIGHT  = 7;
  localparam int A      = 8;
  localparam int X      = 9;
  localparam int L      = 10;
  localparam int R      = 11;

endpackage

// File: rtl/snes_edge_sync.sv
// Multi-flop synchroniser for an asynchronous console pin.
// Rise = edge_o & level_o, fall = edge_o & ~level_o.
module snes_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic pin_i,
  output logic level_o,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign edge_o  = sync_q[SYNC_STAGES-1] ^ prev_q;

endmodule

// File: rtl/snes_multi_encoder.sv
// Multi-source SNES controller encoder: holds NUM_SRC button words, selects or
// merges them by mode (with automatic owner hand-over) and shifts the result out.
module snes_multi_encoder
  import snes_pkg::*;
#(
  parameter int NUM_SRC     = 3,
  parameter int SRC_WIDTH   = 12,
  parameter int FRAME_BITS  = SNES_FRAME_BITS,
  parameter int HOLD_CYCLES = 20000,
  parameter int SYNC_STAGES = 2,
  localparam int SEL_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_SRC*SRC_WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]           src_valid,
  input  logic [1:0]                   mode,
  input  logic [SEL_W-1:0]             sel,
  input  logic                         snes_latch,
  input  logic                         snes_clk,
  output logic                         snes_out,
  output logic [SEL_W-1:0]             active_src,
  output logic                         frame_done
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam int BC_W  = $clog2(FRAME_BITS + 1);

  logic lat_lvl, lat_edge, clk_lvl, clk_edge, lat_fall, clk_rise;

  snes_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lat_sync (
    .clock(clock), .reset(reset), .pin_i(snes_latch), .level_o(lat_lvl), .edge_o(lat_edge)
  );
  snes_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
    .clock(clock), .reset(reset), .pin_i(snes_clk), .level_o(clk_lvl), .edge_o(clk_edge)
  );

  assign lat_fall = lat_edge & ~lat_lvl;
  assign clk_rise = clk_edge & clk_lvl;

  logic [SRC_WIDTH-1:0] hold_q [NUM_SRC];
  logic [CNT_W-1:0]     idle_q [NUM_SRC];
  logic [SEL_W-1:0]     owner_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        hold_q[i] <= '0;
        idle_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (src_valid[i]) hold_q[i] <= src_data[i*SRC_WIDTH +: SRC_WIDTH];
        if (hold_q[i] != '0) idle_q[i] <= '0;
        else if (idle_q[i] != CNT_W'(HOLD_CYCLES)) idle_q[i] <= idle_q[i] + 1'b1;
      end
    end
  end

  logic [SRC_WIDTH-1:0]  sel_word, own_word, merge_word;
  logic [FRAME_BITS-1:0] next_word;
  logic                  own_idle, cand_found;
  logic [SEL_W-1:0]      cand_idx;

  // Candidate owner is the lowest-index pressed source other than the current owner
  always_comb begin
    sel_word   = '0;
    own_word   = '0;
    merge_word = '0;
    own_idle   = 1'b0;
    cand_found = 1'b0;
    cand_idx   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (int'(sel) == i) sel_word = hold_q[i];
      if (int'(owner_q) == i) begin
        own_word = hold_q[i];
        own_idle = (idle_q[i] == CNT_W'(HOLD_CYCLES));
      end
      merge_word = merge_word | hold_q[i];
      if (!cand_found && int'(owner_q) != i && hold_q[i] != '0) begin
        cand_found = 1'b1;
        cand_idx   = SEL_W'(i);
      end
    end
    next_word = '0;
    case (mode_e'(mode))
      FIXED:   next_word[SRC_WIDTH-1:0] = sel_word;
      AUTO:    next_word[SRC_WIDTH-1:0] = own_word;
      MERGE:   next_word[SRC_WIDTH-1:0] = merge_word;
      default: next_word = '0;
    endcase
  end

  frame_state_e          state_q;
  logic [FRAME_BITS-1:0] sr_q, sr_shift;
  logic [BC_W-1:0]       bit_cnt_q;
  logic                  snes_out_q, frame_done_q;

  assign sr_shift = sr_q >> 1;

  // Hand-over is only allowed between frames so the console never sees a mixed word
  always_ff @(posedge clock) begin
    if (reset) begin
      owner_q <= '0;
    end else if (mode_e'(mode) == AUTO && (state_q == IDLE || state_q == DONE) &&
                 !lat_lvl && own_idle && cand_found) begin
      owner_q <= cand_idx;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      sr_q         <= '0;
      bit_cnt_q    <= '0;
      snes_out_q   <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (lat_lvl) begin
        state_q    <= LOAD;
        sr_q       <= next_word;
        bit_cnt_q  <= '0;
        snes_out_q <= ~next_word[0];
      end else begin
        case (state_q)
          LOAD: if (lat_fall) state_q <= SHIFT;
          SHIFT: begin
            if (clk_rise) begin
              sr_q      <= sr_shift;
              bit_cnt_q <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == BC_W'(FRAME_BITS - 1)) begin
                frame_done_q <= 1'b1;
                state_q      <= DONE;
                snes_out_q   <= 1'b0;
              end else begin
                snes_out_q <= ~sr_shift[0];
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign snes_out   = snes_out_q;
  assign frame_done = frame_done_q;
  assign active_src = (mode_e'(mode) == FIXED) ? sel : owner_q;

endmodule
